dot_product_mac: RTL and testbench



---
 rtl/dot_product_pkg.sv | 14 +
 rtl/dot_product_mac_mac_unit.sv | 31 +++
 rtl/dot_product_mac.sv | 81 ++++++++
 tb/tb_dot_product_mac.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared types and sizing helpers for the streaming dot-product engine.
package dot_product_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Width that holds N_TAPS full-scale products without overflow in either mode.
    function automatic int acc_width(input int data_w, input int n_taps);
        return 2 * data_w + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/dot_product_mac_mac_unit.sv
// Combinational extend-multiply-add: acc_out = acc_in + x*h at accumulator width.
module mac_unit #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] h,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out
);

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] h_ext;
    logic signed [ACC_W-1:0] prod;

    generate
        if (SIGNED != 0) begin : g_sext
            assign x_ext = ACC_W'($signed(x));
            assign h_ext = ACC_W'($signed(h));
        end else begin : g_zext
            assign x_ext = ACC_W'(x);
            assign h_ext = ACC_W'(h);
        end
    endgenerate

    // Truncating to ACC_W is exact: the true product always fits.
    assign prod    = x_ext * h_ext;
    assign acc_out = acc_in + $unsigned(prod);

endmodule

// File: rtl/dot_product_mac.sv
// Streaming dot-product engine: accumulates N_TAPS (x, h) pairs, then holds the sum for the consumer.
module dot_product_mac
    import dot_product_pkg::*;
#(
    parameter int   DATA_W = 4,
    parameter int   N_TAPS = 10,
    parameter int   SIGNED = 0,
    localparam int  ACC_W  = acc_width(DATA_W, N_TAPS),
    localparam int  CNT_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] h_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy
);

    state_e                state;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      tap_cnt;
    logic [ACC_W-1:0]      acc_next;
    logic                  accept;
    logic                  last_tap;
    logic                  release_out;

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .x       (x_in),
        .h       (h_in),
        .acc_in  (acc),
        .acc_out (acc_next)
    );

    // In HOLD a new pair may only enter when the held result leaves the same cycle.
    assign in_ready    = !clr && ((state == ACCUM) || out_ready);
    assign accept      = in_valid && in_ready;
    assign last_tap    = (tap_cnt == CNT_W'(N_TAPS - 1));
    assign release_out = (state == HOLD) && out_ready;
    assign busy        = (tap_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            tap_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (release_out) begin
                out_valid <= 1'b0;
                state     <= ACCUM;
            end
            // clr only aborts the partial sum; a held result still completes its handshake.
            if (clr) begin
                acc     <= '0;
                tap_cnt <= '0;
            end else if (accept) begin
                if (last_tap) begin
                    out_data  <= acc_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    tap_cnt   <= '0;
                    state     <= HOLD;
                end else begin
                    acc     <= acc_next;
                    tap_cnt <= tap_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
// Scoreboard bench: unsigned and signed instances share stimulus; a pair-list model predicts results.
module tb_dot_product_mac;

    localparam int DATA_W = 4;
    localparam int N_TAPS = 10;
    localparam int ACC_W  = 2 * DATA_W + $clog2(N_TAPS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [DATA_W-1:0] x_in = '0;
    logic [DATA_W-1:0] h_in = '0;

    logic in_ready_u, out_valid_u, busy_u;
    logic in_ready_s, out_valid_s, busy_s;
    logic [ACC_W-1:0] out_data_u, out_data_s;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DATA_W-1:0] xs[$];
    logic [DATA_W-1:0] hs[$];
    logic [ACC_W-1:0]  exp_u[$];
    logic [ACC_W-1:0]  exp_s[$];
    bit                pend = 1'b0;

    always #5 clk = ~clk;

    dot_product_mac #(.DATA_W(DATA_W), .N_TAPS(N_TAPS), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_u),
        .x_in(x_in), .h_in(h_in), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .busy(busy_u)
    );

    dot_product_mac #(.DATA_W(DATA_W), .N_TAPS(N_TAPS), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
        .x_in(x_in), .h_in(h_in), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .busy(busy_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int as_signed(input logic [DATA_W-1:0] v);
        int r;
        r = int'(v);
        if (v[DATA_W-1]) r = r - (1 << DATA_W);
        return r;
    endfunction

    // Model: a vector is the list of accepted pairs; it completes when the list reaches N_TAPS.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            xs.delete(); hs.delete(); exp_u.delete(); exp_s.delete();
            pend = 1'b0;
        end else begin
            bit take;
            take = in_valid && !clr && (!pend || out_ready);
            if (pend && out_ready) pend = 1'b0;
            if (clr) begin
                xs.delete(); hs.delete();
            end else if (take) begin
                xs.push_back(x_in);
                hs.push_back(h_in);
                if (xs.size() == N_TAPS) begin
                    int su, ss;
                    su = 0; ss = 0;
                    for (int i = 0; i < N_TAPS; i++) begin
                        su += int'(xs[i]) * int'(hs[i]);
                        ss += as_signed(xs[i]) * as_signed(hs[i]);
                    end
                    exp_u.push_back(ACC_W'(su));
                    exp_s.push_back(ACC_W'(ss));
                    pend = 1'b1;
                    xs.delete(); hs.delete();
                end
            end
        end
    end

    // Monitor: handshake and status checks every cycle, result pops on each output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_u", in_ready_u, !clr && (!pend || out_ready));
            chk("in_ready_s", in_ready_s, !clr && (!pend || out_ready));
            chk("out_valid_u", out_valid_u, pend);
            chk("out_valid_s", out_valid_s, pend);
            chk("busy_u", busy_u, xs.size() != 0);
            chk("busy_s", busy_s, xs.size() != 0);
            if (out_valid_u && out_ready) begin
                if (exp_u.size() == 0) chk("unexpected_out_u", 1, 0);
                else chk("out_data_u", out_data_u, exp_u.pop_front());
            end
            if (out_valid_s && out_ready) begin
                if (exp_s.size() == 0) chk("unexpected_out_s", 1, 0);
                else chk("out_data_s", out_data_s, exp_s.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] h);
        in_valid = v;
        x_in = x;
        h_in = h;
        @(posedge clk);
        #1;
    endtask

    task automatic pairs(input int n, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] h);
        for (int i = 0; i < n; i++) drive(1'b1, x, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        chk("rst_out_data_u", out_data_u, 0);
        chk("rst_out_data_s", out_data_s, 0);
        chk("rst_out_valid", out_valid_u | out_valid_s, 0);
        chk("rst_busy", busy_u | busy_s, 0);
        chk("rst_in_ready", in_ready_u & in_ready_s, 1);

        // Full-scale unsigned vector, then signed extremes.
        out_ready = 1'b1;
        pairs(N_TAPS, 4'd15, 4'd15);
        idle(3);
        pairs(N_TAPS, 4'h8, 4'h8);
        pairs(N_TAPS, 4'h8, 4'h7);
        idle(3);

        // Backpressure: held result blocks new pairs until released.
        for (int i = 1; i <= N_TAPS; i++) drive(1'b1, DATA_W'(i), 4'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_data_u", out_data_u, 55);
            drive(1'b1, 4'd9, 4'd9);
        end
        out_ready = 1'b1;
        pairs(N_TAPS, 4'd9, 4'd2);
        idle(3);

        // Continuous stream, no bubbles.
        pairs(3 * N_TAPS, 4'd2, 4'd3);
        idle(3);

        // Abort mid-vector.
        pairs(4, 4'd5, 4'd5);
        clr = 1'b1;
        drive(1'b1, 4'd5, 4'd5);
        clr = 1'b0;
        pairs(N_TAPS, 4'd1, 4'd1);
        idle(3);

        // clr on the completing pair drops it.
        pairs(N_TAPS - 1, 4'd2, 4'd2);
        clr = 1'b1;
        drive(1'b1, 4'd2, 4'd2);
        clr = 1'b0;
        idle(3);

        // Asynchronous reset mid-cycle, mid-vector.
        pairs(N_TAPS, 4'd1, 4'd7);
        out_ready = 1'b0;
        pairs(5, 4'd6, 4'd6);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid_u | out_valid_s, 0);
        chk("arst_out_data", out_data_u | out_data_s, 0);
        chk("arst_busy", busy_u | busy_s, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        pairs(N_TAPS, 4'd3, 4'd4);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 29) == 0);
            drive($urandom_range(0, 3) != 0, DATA_W'($urandom), DATA_W'($urandom));
        end
        clr = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drain_u", exp_u.size(), 0);
        chk("drain_s", exp_s.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
